// File: rtl/pa_lsu_vb_wb_ctrl.sv
// Victim-buffer write-back responder: picks a requesting VB entry round-robin,
// bursts its 256-bit line to the BIU as 8 x 32-bit beats, then pulses completion.
module pa_lsu_vb_wb_ctrl #(
    parameter int ENTRY_NUM = 2,
    parameter int IDX_W     = 1
) (
    input  logic                      forever_cpuclk,
    input  logic                      cpurst,
    input  logic [ENTRY_NUM-1:0]      vb_entry_biu_req,
    input  logic [27*ENTRY_NUM-1:0]   vb_entry_addr,
    input  logic [256*ENTRY_NUM-1:0]  vb_entry_data,
    output logic [ENTRY_NUM-1:0]      vb_wb_grant,
    output logic [ENTRY_NUM-1:0]      vb_wb_cmplt,
    output logic                      lsu_biu_wb_req,
    output logic [31:0]               lsu_biu_wb_addr,
    output logic [31:0]               lsu_biu_wb_data,
    output logic                      lsu_biu_wb_data_vld,
    output logic                      lsu_biu_wb_last,
    input  logic                      biu_lsu_wb_addr_ack,
    input  logic                      biu_lsu_wb_data_ack,
    input  logic                      biu_lsu_wb_resp_vld,
    output logic [1:0]                vb_wb_dbginfo
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DATA = 2'b10,
        RESP = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [26:0]        addr_q, addr_d;
    logic [255:0]       line_q, line_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W:0]     rr_sum;
    logic               grant_fire;
    logic               cmplt_fire;

    logic [26:0]        entry_addr [ENTRY_NUM];
    logic [255:0]       entry_line [ENTRY_NUM];
    logic [31:0]        line_beat  [8];

    for (genvar g = 0; g < ENTRY_NUM; g++) begin : g_entry
        assign entry_addr[g] = vb_entry_addr[27*g +: 27];
        assign entry_line[g] = vb_entry_data[256*g +: 256];
    end

    for (genvar b = 0; b < 8; b++) begin : g_beat
        assign line_beat[b] = line_q[32*b +: 32];
    end

    // Round-robin search starts one past the last winner and wraps; the first
    // requesting entry found wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_sum    = '0;
        for (int i = 1; i <= ENTRY_NUM; i++) begin
            rr_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
            if (rr_sum >= (IDX_W+1)'(ENTRY_NUM))
                rr_sum = rr_sum - (IDX_W+1)'(ENTRY_NUM);
            if (!win_found && vb_entry_biu_req[rr_sum[IDX_W-1:0]]) begin
                win_found = 1'b1;
                win_idx   = rr_sum[IDX_W-1:0];
            end
        end
    end

    assign grant_fire = (state_q == IDLE) && win_found;
    assign cmplt_fire = (state_q == RESP) && biu_lsu_wb_resp_vld;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        idx_d      = idx_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d  = REQ;
                    rr_ptr_d = win_idx;
                    idx_d    = win_idx;
                end
            end
            REQ: begin
                if (biu_lsu_wb_addr_ack) begin
                    state_d    = DATA;
                    beat_cnt_d = 3'd0;
                end
            end
            DATA: begin
                if (biu_lsu_wb_data_ack) begin
                    beat_cnt_d = beat_cnt_q + 3'd1;
                    if (beat_cnt_q == 3'd7)
                        state_d = RESP;
                end
            end
            RESP: begin
                if (biu_lsu_wb_resp_vld)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The line snapshot is taken on the grant so a later flush of the entry
    // cannot disturb a burst already in flight.
    always_comb begin
        addr_d = addr_q;
        line_d = line_q;
        if (grant_fire) begin
            addr_d = entry_addr[win_idx];
            line_d = entry_line[win_idx];
        end
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            state_q    <= IDLE;
            beat_cnt_q <= 3'd0;
            rr_ptr_q   <= IDX_W'(ENTRY_NUM - 1);
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            idx_q      <= idx_d;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        addr_q <= addr_d;
        line_q <= line_d;
    end

    // Grant and completion are same-cycle pulses; both are forced low while
    // reset is held so an abort leaves every output quiet.
    always_comb begin
        vb_wb_grant = '0;
        vb_wb_cmplt = '0;
        for (int k = 0; k < ENTRY_NUM; k++) begin
            vb_wb_grant[k] = grant_fire && !cpurst && (win_idx == IDX_W'(k));
            vb_wb_cmplt[k] = cmplt_fire && !cpurst && (idx_q == IDX_W'(k));
        end
    end

    assign lsu_biu_wb_req      = (state_q == REQ);
    assign lsu_biu_wb_addr     = lsu_biu_wb_req ? {addr_q, 5'b0} : 32'd0;
    assign lsu_biu_wb_data_vld = (state_q == DATA);
    assign lsu_biu_wb_data     = lsu_biu_wb_data_vld ? line_beat[beat_cnt_q] : 32'd0;
    assign lsu_biu_wb_last     = lsu_biu_wb_data_vld && (beat_cnt_q == 3'd7);
    assign vb_wb_dbginfo       = state_q;

endmodule

// File: doc/pa_lsu_vb_wb_ctrl.md
Name: pa_lsu_vb_wb_ctrl

Overview:
Responder side of the victim-buffer write-back handshake. Each VB entry in WB state raises a BIU request. This block picks one requesting entry round-robin, pulses its grant and captures the entry's 27-bit line address and 256-bit line. It then drives the line onto the LSU-to-BIU write channel as an 8-beat, 32-bit incrementing burst. When the BIU response arrives it pulses that entry's completion so the entry can pop. Sits in the LSU between the VB entries and the BIU.

Parameters:
ENTRY_NUM, 2, number of VB entries served (≥2).
IDX_W, 1, index width, equal to clog2(ENTRY_NUM).

Ports:
forever_cpuclk  input  1  clock; the only clock.
cpurst  input  1  asynchronous, active-high reset.
vb_entry_biu_req  input  ENTRY_NUM  per-entry write-back request (level).
vb_entry_addr  input  27*ENTRY_NUM  per-entry line address, PA[31:5]; entry k occupies [27k+26:27k].
vb_entry_data  input  256*ENTRY_NUM  per-entry line data; entry k occupies [256k+255:256k].
vb_wb_grant  output  ENTRY_NUM  one-hot grant pulse.
vb_wb_cmplt  output  ENTRY_NUM  one-hot completion pulse.
lsu_biu_wb_req  output  1  address-phase request.
lsu_biu_wb_addr  output  32  burst start address {line_addr, 5'b0}.
lsu_biu_wb_data  output  32  current beat data.
lsu_biu_wb_data_vld  output  1  beat valid.
lsu_biu_wb_last  output  1  final beat (beat 7).
biu_lsu_wb_addr_ack  input  1  address phase accepted.
biu_lsu_wb_data_ack  input  1  current beat accepted.
biu_lsu_wb_resp_vld  input  1  burst write complete.
vb_wb_dbginfo  output  2  current FSM state.

Behaviour:
- State machine: IDLE=00, REQ=01, DATA=10, RESP=11. Reset (cpurst=1) forces IDLE, beat_cnt=0, rr_ptr=ENTRY_NUM-1. All outputs are 0 in IDLE when no request is present.
- IDLE: if any vb_entry_biu_req bit is set, select the winner by round-robin (search starts at rr_ptr+1 and wraps). vb_wb_grant[winner] is driven combinationally in that same cycle.
- Grant cycle effects: latch winner index, addr, and 256-bit line into local registers; set rr_ptr=winner; go to REQ. At most one grant per burst; no grant outside IDLE.
- REQ: lsu_biu_wb_req=1 with lsu_biu_wb_addr={addr_q,5'b0}. Hold until biu_lsu_wb_addr_ack, then go to DATA with beat_cnt=0.
- DATA: lsu_biu_wb_data_vld=1 and lsu_biu_wb_data=line_q[32*beat_cnt+31:32*beat_cnt]. Each data_ack increments beat_cnt (3-bit).
- lsu_biu_wb_last=(beat_cnt==7) in DATA. data_ack with last set goes to RESP and wraps beat_cnt to 0.
- Without data_ack, data, vld, and last hold stable.
- RESP: wait for biu_lsu_wb_resp_vld. In that cycle, vb_wb_cmplt[idx_q]=1 combinationally (a single-cycle pulse) and the next state is IDLE.
- A new grant is possible in the cycle after cmplt. Minimum occupancy is 11 cycles per line: grant, addr, 8 beats, resp.
- resp_vld is sampled only in RESP. resp_vld in DATA, including the same cycle as the last data_ack, is ignored. addr_ack and data_ack are ignored outside REQ and DATA respectively.
- Request dropped after grant (e.g. the entry was flushed): the burst still completes and cmplt still pulses the latched index; the entry ignores it.
- Asserting cpurst mid-burst aborts immediately: outputs go to 0 and state to IDLE.
- vb_wb_dbginfo equals the state register.

Test Plan:
- Single entry: req[0]=1, addr=27'h0123456, line=256'h{beat7..beat0 = 8'h07..8'h00 replicated}. Required: grant[0] pulse in cycle 0; wb_addr=32'h02468AC0; 8 beats in order 0..7 with last on beat 7; after resp_vld, exactly one cmplt[0] pulse.
- BIU backpressure: addr_ack delayed 3 cycles and data_ack withheld 2 cycles on beat 4. Required: req, data, and last held stable; no beat skipped or duplicated; beat_cnt stops at 4 while ack is withheld.
- Round-robin: req=2'b11 held continuously. Required grant order is entry0, entry1, entry0. Each grant appears only in IDLE, and cmplt index matches the preceding grant.
- Early response: resp_vld pulsed during beat 3 and again with the last data_ack. Required: no cmplt and state stays in DATA/RESP. The later resp_vld in RESP produces cmplt.
- Reset mid-burst: cpurst asserted at beat 5. Required: all outputs 0 and dbginfo=00 immediately. After release with req[1]=1, grant[1] is first (rr_ptr reset to ENTRY_NUM-1).
- Dropped request: req[0] deasserted right after grant. Required: the full 8-beat burst still issues and cmplt[0] pulses once.
